// File: rtl/key_filter_pkg.sv
// -----------------------------------------------------------------------------
// key_filter_pkg
// Shared types and constants for the push-button debounce block.
//   key_state_t      : debounce FSM state encoding
//   KEY_CNT_MAX_20MS : default debounce window minus one (20 ms at 50 MHz)
//   key_cnt_width()  : width of the debounce counter for a given CNT_MAX
// -----------------------------------------------------------------------------
package key_filter_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_FILT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_FILT = 2'd3
  } key_state_t;

  localparam int unsigned KEY_CNT_MAX_20MS = 999_999;

  // Counter must hold 0..CNT_MAX; guard against a zero width for tiny windows.
  function automatic int unsigned key_cnt_width(input int unsigned cnt_max);
    int unsigned w;
    w = $clog2(cnt_max + 1);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/key_filter_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-stage synchroniser for a single asynchronous input bit. Both stages
// reset to RST_VAL so the synchronised output reads the inactive level while
// the system is held in reset.
// Ports:
//   clk_i   : destination clock
//   rst_n_i : asynchronous active-low reset
//   d_i     : asynchronous input
//   q_o     : synchronised output (two clk_i edges of latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/key_filter.sv
// -----------------------------------------------------------------------------
// key_filter
// Debounces and synchronises a mechanical push-button pin. Produces a clean
// registered key level plus single-cycle press / release strobes.
// Parameters:
//   CNT_MAX  : debounce window minus one, in sys_clk cycles (>= 1)
//   KEY_IDLE : pin level when the key is not pressed
// Ports:
//   sys_clk     : system clock
//   sys_rst_n   : asynchronous active-low reset
//   key_in      : raw, asynchronous, bouncing key pin
//   key_level   : debounced key level, same polarity as the pin
//   key_press   : one-cycle strobe on an accepted KEY_IDLE -> ~KEY_IDLE change
//   key_release : one-cycle strobe on an accepted ~KEY_IDLE -> KEY_IDLE change
// -----------------------------------------------------------------------------
module key_filter
  import key_filter_pkg::*;
#(
  parameter int unsigned CNT_MAX  = KEY_CNT_MAX_20MS,
  parameter logic        KEY_IDLE = 1'b1
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int unsigned CNT_W = key_cnt_width(CNT_MAX);

  // The cycle that leaves IDLE/HELD has already seen the new level once, so
  // the filter state needs CNT_MAX further matching samples. With cnt
  // starting at 0 on entry, the last of those is seen while cnt = CNT_MAX-1.
  // This makes the total window exactly CNT_MAX+1 samples of key_s.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CNT_MAX - 1);

  logic             key_s;
  key_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             press_q;
  logic             release_q;
  logic             key_active;

  // Stage: pin synchronisation
  sync_2ff #(
    .RST_VAL (KEY_IDLE)
  ) u_sync (
    .clk_i   (sys_clk),
    .rst_n_i (sys_rst_n),
    .d_i     (key_in),
    .q_o     (key_s)
  );

  assign key_active = (key_s != KEY_IDLE);
  assign cnt_d      = cnt_q + 1'b1;

  // Stage: debounce FSM, counter and registered outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= KEY_IDLE;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (key_active) begin
            state_q <= PRESS_FILT;
          end
        end
        PRESS_FILT: begin
          if (!key_active) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == LAST_CNT) begin
            state_q <= HELD;
            cnt_q   <= '0;
            level_q <= ~KEY_IDLE;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        HELD: begin
          cnt_q <= '0;
          if (!key_active) begin
            state_q <= RELEASE_FILT;
          end
        end
        RELEASE_FILT: begin
          if (key_active) begin
            state_q <= HELD;
            cnt_q   <= '0;
          end else if (cnt_q == LAST_CNT) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= KEY_IDLE;
            release_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: tb/tb_key_filter.sv
module tb_key_filter;

  localparam int unsigned CNT_MAX = 9;
  localparam int          LAT     = CNT_MAX + 3;

  logic sys_clk;
  logic sys_rst_n;
  logic key_in;
  logic key_level;
  logic key_press;
  logic key_release;

  typedef struct {
    bit is_press;
    int cyc;
    bit level;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  bit   mon_level = 1'b1;

  key_filter #(
    .CNT_MAX  (CNT_MAX),
    .KEY_IDLE (1'b1)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .key_in      (key_in),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Wait n rising edges, then move 1 ns past the edge to drive/sample.
  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Expected strobe lands LAT edges after a change driven just after edge cyc.
  task automatic expect_strobe(input bit is_press);
    exp_t e;
    e.is_press = is_press;
    e.cyc      = cyc + LAT;
    e.level    = is_press ? 1'b0 : 1'b1;
    exp_q.push_back(e);
  endtask

  // Monitor: compares every strobe against the scoreboard and tracks the
  // level the bench expects between strobes.
  always @(negedge sys_clk) begin
    exp_t e;
    if (!sys_rst_n) begin
      mon_level = 1'b1;
    end else begin
      chk("strobes_exclusive", int'(key_press & key_release), 0);
      if (key_press || key_release) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_strobe: press=%0b release=%0b at cycle %0d, none expected",
                   key_press, key_release, cyc);
        end else begin
          e = exp_q.pop_front();
          chk(e.is_press ? "press_strobe" : "release_strobe",
              int'(e.is_press ? key_press : key_release), 1);
          chk("strobe_cycle", cyc, e.cyc);
          chk("strobe_level", int'(key_level), int'(e.level));
          mon_level = e.level;
        end
      end else begin
        chk("level_steady", int'(key_level), int'(mon_level));
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_level"},   int'(key_level),   1);
    chk({tag, "_press"},   int'(key_press),   0);
    chk({tag, "_release"}, int'(key_release), 0);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    key_in    = 1'b0;

    // Reset held with key pressed: outputs stay at reset values.
    step(4);
    chk_reset_outputs("reset_hold");
    step(1);
    chk_reset_outputs("reset_hold2");
    sys_rst_n = 1'b1;
    expect_strobe(1'b1);
    step(20);

    // Release from HELD.
    key_in = 1'b1;
    expect_strobe(1'b0);
    step(20);

    // Clean press, then release.
    key_in = 1'b0;
    expect_strobe(1'b1);
    step(20);
    key_in = 1'b1;
    expect_strobe(1'b0);
    step(20);

    // Bounce: 5 low, 1 high, then low and held.
    key_in = 1'b0;
    step(5);
    key_in = 1'b1;
    step(1);
    key_in = 1'b0;
    expect_strobe(1'b1);
    step(20);
    key_in = 1'b1;
    expect_strobe(1'b0);
    step(20);

    // Glitch one cycle short of the window: no strobe expected.
    key_in = 1'b0;
    step(9);
    key_in = 1'b1;
    step(20);
    chk("glitch_level", int'(key_level), 1);

    // Press, then asynchronous reset while HELD.
    key_in = 1'b0;
    expect_strobe(1'b1);
    step(16);
    chk("held_level", int'(key_level), 0);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst_held");
    step(2);
    sys_rst_n = 1'b1;
    expect_strobe(1'b1);
    step(20);
    key_in = 1'b1;
    expect_strobe(1'b0);
    step(20);

    // Reset while PRESS_FILT has cnt = 6, then filter restarts from 0.
    key_in = 1'b0;
    step(9);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst_filt");
    step(2);
    sys_rst_n = 1'b1;
    expect_strobe(1'b1);
    step(20);
    key_in = 1'b1;
    expect_strobe(1'b0);
    step(20);

    chk("scoreboard_empty", exp_q.size(), 0);
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      $display("FAIL missing_strobe: press=%0b never seen, expected at cycle %0d", e.is_press, e.cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
